// File: rtl/pulse_burst_if.sv
// Command/status bundle between a peripheral driver (master) and the pulse burst controller (slave).
interface pulse_burst_if #(
  parameter int N = 8,
  parameter int C = 8
);
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] period;
  logic [C-1:0] count;
  logic         ena;
  logic         abort;
  logic         pulse;
  logic         busy;
  logic         done;
  logic [C-1:0] pulses_left;

  modport master (
    output start_valid, period, count, ena, abort,
    input  start_ready, pulse, busy, done, pulses_left
  );

  modport slave (
    input  start_valid, period, count, ena, abort,
    output start_ready, pulse, busy, done, pulses_left
  );
endinterface

// File: rtl/pulse_burst_controller.sv
// Emits a bounded burst of single-cycle pulses spaced period+1 enabled cycles apart,
// with pause (ena low), abort and a one-cycle done strobe at the end of a full burst.
module pulse_burst_controller #(
  parameter int N = 8,
  parameter int C = 8
) (
  input  logic             clk,
  input  logic             rst,
  pulse_burst_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] period_reg, period_next;
  logic [C-1:0] left_reg, left_next;
  logic [N-1:0] counter_reg, counter_next;
  logic         fire;
  logic         tick;
  logic         accept;

  // Counter only advances while below period_reg, so it saturates at the compare value.
  assign tick   = (counter_reg >= period_reg);
  assign accept = bus.start_valid && (state_reg == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      period_reg  <= '0;
      left_reg    <= '0;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      period_reg  <= period_next;
      left_reg    <= left_next;
      counter_reg <= counter_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    period_next  = period_reg;
    left_next    = left_reg;
    counter_next = counter_reg;
    fire         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          period_next  = bus.period;
          left_next    = bus.count;
          counter_next = '0;
          state_next   = (bus.count == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        // Abort wins over ena and tick: no pulse, no done strobe.
        if (bus.abort) begin
          state_next   = IDLE;
          counter_next = '0;
          left_next    = '0;
        end else if (bus.ena) begin
          if (tick && (left_reg != '0)) begin
            fire         = 1'b1;
            counter_next = '0;
            left_next    = left_reg - 1'b1;
            if (left_reg == C'(1)) begin
              state_next = DONE;
            end
          end else begin
            counter_next = counter_reg + 1'b1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next   = IDLE;
        counter_next = '0;
        left_next    = '0;
      end
    endcase
  end

  // Strobes are masked during reset so a reset mid-burst silences the outputs at once.
  assign bus.start_ready = (state_reg == IDLE) && !rst;
  assign bus.pulse       = fire && !rst;
  assign bus.busy        = (state_reg == RUN) && !rst;
  assign bus.done        = (state_reg == DONE) && !rst;
  assign bus.pulses_left = left_reg;

endmodule

// File: tb/tb_pulse_burst_controller.sv
// Directed vector bench for pulse_burst_controller: a per-cycle vector table plus hand sequences.
module tb_pulse_burst_controller;
  logic clk;
  logic rst;

  pulse_burst_if #(.N(8), .C(8)) bus ();

  pulse_burst_controller #(.N(8), .C(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {start_ready, pulse, busy, done, pulses_left[7:0]}
  typedef struct {
    logic       rst;
    logic       sv;
    logic [7:0] per;
    logic [7:0] cnt;
    logic       ena;
    logic       ab;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares = 0;

  task automatic add(input int n, input logic r, input logic sv, input logic [7:0] per,
                     input logic [7:0] cnt, input logic ena, input logic ab,
                     input logic rdy, input logic pl, input logic bs, input logic dn,
                     input logic [7:0] left);
    vec_t v;
    v.rst = r; v.sv = sv; v.per = per; v.cnt = cnt; v.ena = ena; v.ab = ab;
    v.exp = {rdy, pl, bs, dn, left};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic sv, input logic [7:0] per,
                       input logic [7:0] cnt, input logic ena, input logic ab);
    rst = r; bus.start_valid = sv; bus.period = per; bus.count = cnt;
    bus.ena = ena; bus.abort = ab;
  endtask

  task automatic check_all(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {bus.start_ready, bus.pulse, bus.busy, bus.done, bus.pulses_left};
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got rdy/pulse/busy/done/left=%03h, want %03h", name, act, exp);
    end else begin
      $display("ok   %s: rdy/pulse/busy/done/left=%03h", name, act);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors_applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    int first_pulse;
    int pulse_total;

    // Basic burst: period=3, count=2
    add(1, 1,0,0,0,1,0, 0,0,0,0,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);
    add(1, 0,1,3,2,1,0, 1,0,0,0,0);
    add(3, 0,0,0,0,1,0, 0,0,1,0,2);
    add(1, 0,0,0,0,1,0, 0,1,1,0,2);
    add(3, 0,0,0,0,1,0, 0,0,1,0,1);
    add(1, 0,0,0,0,1,0, 0,1,1,0,1);
    add(1, 0,0,0,0,1,0, 0,0,0,1,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);
    // Back-to-back: period=0, count=4, start_valid held high; then empty burst count=0
    add(1, 0,1,0,4,1,0, 1,0,0,0,0);
    add(1, 0,1,0,4,1,0, 0,1,1,0,4);
    add(1, 0,1,0,4,1,0, 0,1,1,0,3);
    add(1, 0,1,0,4,1,0, 0,1,1,0,2);
    add(1, 0,1,0,4,1,0, 0,1,1,0,1);
    add(1, 0,1,0,4,1,0, 0,0,0,1,0);
    add(1, 0,1,5,0,1,0, 1,0,0,0,0);
    add(1, 0,0,0,0,1,0, 0,0,0,1,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);
    // Pause: period=2, count=3, ena low for 5 cycles after first pulse
    add(1, 0,1,2,3,1,0, 1,0,0,0,0);
    add(2, 0,0,0,0,1,0, 0,0,1,0,3);
    add(1, 0,0,0,0,1,0, 0,1,1,0,3);
    add(5, 0,0,0,0,0,0, 0,0,1,0,2);
    add(2, 0,0,0,0,1,0, 0,0,1,0,2);
    add(1, 0,0,0,0,1,0, 0,1,1,0,2);
    add(2, 0,0,0,0,1,0, 0,0,1,0,1);
    add(1, 0,0,0,0,1,0, 0,1,1,0,1);
    add(1, 0,0,0,0,1,0, 0,0,0,1,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);
    // Abort and ignore: period=4, count=10, stray command mid-burst, abort after 3rd pulse
    add(1, 0,1,4,10,1,0, 1,0,0,0,0);
    add(4, 0,0,0,0,1,0, 0,0,1,0,10);
    add(1, 0,0,0,0,1,0, 0,1,1,0,10);
    add(1, 0,0,0,0,1,0, 0,0,1,0,9);
    add(1, 0,1,1,1,1,0, 0,0,1,0,9);
    add(2, 0,0,0,0,1,0, 0,0,1,0,9);
    add(1, 0,0,0,0,1,0, 0,1,1,0,9);
    add(4, 0,0,0,0,1,0, 0,0,1,0,8);
    add(1, 0,0,0,0,1,0, 0,1,1,0,8);
    add(1, 0,0,0,0,1,1, 0,0,1,0,7);
    add(1, 0,0,0,0,1,1, 1,0,0,0,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);
    // Reset mid-run: period=1, count=8, rst after 2nd pulse, then a fresh burst of 2
    add(1, 0,1,1,8,1,0, 1,0,0,0,0);
    add(1, 0,0,0,0,1,0, 0,0,1,0,8);
    add(1, 0,0,0,0,1,0, 0,1,1,0,8);
    add(1, 0,0,0,0,1,0, 0,0,1,0,7);
    add(1, 0,0,0,0,1,0, 0,1,1,0,7);
    add(1, 1,0,0,0,1,0, 0,0,0,0,6);
    add(1, 1,0,0,0,1,0, 0,0,0,0,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);
    add(1, 0,1,1,2,1,0, 1,0,0,0,0);
    add(1, 0,0,0,0,1,0, 0,0,1,0,2);
    add(1, 0,0,0,0,1,0, 0,1,1,0,2);
    add(1, 0,0,0,0,1,0, 0,0,1,0,1);
    add(1, 0,0,0,0,1,0, 0,1,1,0,1);
    add(1, 0,0,0,0,1,0, 0,0,0,1,0);
    add(1, 0,0,0,0,1,0, 1,0,0,0,0);

    drive(1, 0, 8'd0, 8'd0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].sv, vecs[i].per, vecs[i].cnt, vecs[i].ena, vecs[i].ab);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Maximum period: first pulse lands 256 cycles after accept, counter never wraps
    @(negedge clk);
    drive(0, 1, 8'hFF, 8'd1, 1'b1, 1'b0);
    #1;
    check_all("maxper_accept", 12'h800);
    first_pulse = 0;
    pulse_total = 0;
    for (int c = 1; c <= 300 && first_pulse == 0; c++) begin
      @(negedge clk);
      drive(0, 0, 8'd0, 8'd0, 1'b1, 1'b0);
      #1;
      if (bus.pulse) begin
        first_pulse = c;
        pulse_total++;
      end
    end
    check_val("maxper_first_pulse_cycle", first_pulse, 256);
    @(negedge clk);
    #1;
    check_all("maxper_done", 12'h100);

    // Abort takes priority over a due tick
    @(negedge clk);
    drive(0, 1, 8'd0, 8'd2, 1'b1, 1'b0);
    #1;
    check_all("abortprio_accept", 12'h800);
    @(negedge clk);
    drive(0, 0, 8'd0, 8'd0, 1'b1, 1'b1);
    #1;
    check_all("abortprio_nopulse", 12'h202);
    @(negedge clk);
    drive(0, 0, 8'd0, 8'd0, 1'b1, 1'b0);
    #1;
    check_all("abortprio_idle", 12'h800);

    // Reset while a tick is due must silence pulse/busy immediately
    @(negedge clk);
    drive(0, 1, 8'd0, 8'd3, 1'b1, 1'b0);
    #1;
    check_all("rstgate_accept", 12'h800);
    @(negedge clk);
    drive(1, 0, 8'd0, 8'd0, 1'b1, 1'b0);
    #1;
    check_all("rstgate_masked", 12'h003);
    @(negedge clk);
    drive(0, 0, 8'd0, 8'd0, 1'b1, 1'b0);
    #1;
    check_all("rstgate_idle", 12'h800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
